// File: rtl/multicycle_controller.sv
// Moore control FSM for the shared multicycle RV32I datapath.
// It decodes the latched instruction and steps through one state per datapath cycle.
// Optional macro MEM_READY_EN: when defined, FETCH, MEMRD and MEMWR wait for mem_ready.
// When the macro is undefined, each memory state lasts exactly one cycle.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       reg_write,
  output logic       illegal_instr,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXER   = 4'd7,
    S_EXEI   = 4'd8,
    S_ALUWB  = 4'd9,
    S_BEQ    = 4'd10,
    S_JAL    = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       pc_write_q, pc_write_d;
  logic       adr_src_q, adr_src_d;
  logic       mem_write_q, mem_write_d;
  logic       ir_write_q, ir_write_d;
  logic [1:0] result_src_q, result_src_d;
  logic [1:0] alu_src_a_q, alu_src_a_d;
  logic [1:0] alu_src_b_q, alu_src_b_d;
  logic [2:0] alu_control_q, alu_control_d;
  logic       reg_write_q, reg_write_d;
  logic       mem_ok;
  logic       fetch_gate;

`ifdef MEM_READY_EN
  assign mem_ok = mem_ready;
`else
  logic mem_ready_unused;
  assign mem_ready_unused = mem_ready;
  assign mem_ok = 1'b1;
`endif

  // ALU operation for register and immediate arithmetic; only R-type can request sub.
  function automatic logic [2:0] alu_decode(input logic is_rtype, input logic [2:0] f3,
                                            input logic f7b5);
    logic [2:0] ctl;
    case (f3)
      3'b000:  ctl = (is_rtype && f7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  ctl = ALU_SLT;
      3'b110:  ctl = ALU_OR;
      3'b111:  ctl = ALU_AND;
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

  // Next state, plus the Moore outputs of that next state so they can be registered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  if (mem_ok) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXER;
          OP_I:         state_d = S_EXEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ok) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ok) state_d = S_FETCH;
      S_EXER:   state_d = S_ALUWB;
      S_EXEI:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_JAL:    state_d = S_ALUWB;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_RST;
    endcase

    illegal_d     = illegal_q | (state_d == S_TRAP);
    pc_write_d    = 1'b0;
    adr_src_d     = 1'b0;
    mem_write_d   = 1'b0;
    ir_write_d    = 1'b0;
    result_src_d  = 2'b00;
    alu_src_a_d   = 2'b00;
    alu_src_b_d   = 2'b00;
    alu_control_d = ALU_ADD;
    reg_write_d   = 1'b0;
    case (state_d)
      S_FETCH: begin
        ir_write_d   = 1'b1;
        pc_write_d   = 1'b1;
        alu_src_b_d  = 2'b10;
        result_src_d = 2'b10;
      end
      S_DECODE: begin
        alu_src_a_d = 2'b01;
        alu_src_b_d = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a_d = 2'b10;
        alu_src_b_d = 2'b01;
      end
      S_MEMRD:  adr_src_d = 1'b1;
      S_MEMWB: begin
        result_src_d = 2'b01;
        reg_write_d  = 1'b1;
      end
      S_MEMWR: begin
        adr_src_d   = 1'b1;
        mem_write_d = 1'b1;
      end
      S_EXER: begin
        alu_src_a_d   = 2'b10;
        alu_control_d = alu_decode(op == OP_R, funct3, funct7b5);
      end
      S_EXEI: begin
        alu_src_a_d   = 2'b10;
        alu_src_b_d   = 2'b01;
        alu_control_d = alu_decode(1'b0, funct3, funct7b5);
      end
      S_ALUWB:  reg_write_d = 1'b1;
      S_BEQ: begin
        alu_src_a_d   = 2'b10;
        alu_control_d = ALU_SUB;
      end
      S_JAL: begin
        alu_src_a_d = 2'b01;
        alu_src_b_d = 2'b10;
        pc_write_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // State register and registered Moore outputs; reset forces every enable low at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RST;
      illegal_q     <= 1'b0;
      pc_write_q    <= 1'b0;
      adr_src_q     <= 1'b0;
      mem_write_q   <= 1'b0;
      ir_write_q    <= 1'b0;
      result_src_q  <= 2'b00;
      alu_src_a_q   <= 2'b00;
      alu_src_b_q   <= 2'b00;
      alu_control_q <= ALU_ADD;
      reg_write_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      illegal_q     <= illegal_d;
      pc_write_q    <= pc_write_d;
      adr_src_q     <= adr_src_d;
      mem_write_q   <= mem_write_d;
      ir_write_q    <= ir_write_d;
      result_src_q  <= result_src_d;
      alu_src_a_q   <= alu_src_a_d;
      alu_src_b_q   <= alu_src_b_d;
      alu_control_q <= alu_control_d;
      reg_write_q   <= reg_write_d;
    end
  end

  // Extender format follows the opcode directly, independent of state.
  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // FETCH loads only in the cycle memory delivers; BEQ loads PC only when operands match.
  assign fetch_gate    = (state_q != S_FETCH) || mem_ok;
  assign ir_write      = ir_write_q & fetch_gate;
  assign pc_write      = (pc_write_q & fetch_gate) | ((state_q == S_BEQ) & zero);
  assign adr_src       = adr_src_q;
  assign mem_write     = mem_write_q;
  assign result_src    = result_src_q;
  assign alu_src_a     = alu_src_a_q;
  assign alu_src_b     = alu_src_b_q;
  assign alu_control   = alu_control_q;
  assign reg_write     = reg_write_q;
  assign illegal_instr = illegal_q;
  assign state_o       = state_q;

endmodule
